// File: rtl/task_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : task_exec_pkg
// Description : Shared types and default widths for the multi-slot task
//               executor (slot state enum, default geometry, stats width).
// Revision    : 1.0 - initial release
// ============================================================================
package task_exec_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_LAT_W     = 3;
  localparam int STAT_W        = 16;

  // Per-slot lifecycle: free, counting down, holding a result for output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } slot_state_e;

  // Slot index width; a single-slot pool still carries a 1-bit index.
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/task_exec_pool_if.sv
`default_nettype none
// ============================================================================
// Module      : task_exec_pool_if
// Description : Dispatch/completion handshake bundle of the task executor.
//               master = scheduler/consumer side, slave = executor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface task_exec_pool_if
  import task_exec_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int LAT_W     = DEF_LAT_W
);

  localparam int SLOT_W = slot_w(NUM_SLOTS);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_task;
  logic [LAT_W-1:0]     in_lat;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_task;
  logic [SLOT_W-1:0]    out_slot;
  logic [NUM_SLOTS-1:0] busy;
  logic [STAT_W-1:0]    stat_done_cnt;

  modport master (
    output in_valid, in_task, in_lat, out_ready,
    input  in_ready, out_valid, out_task, out_slot, busy, stat_done_cnt
  );

  modport slave (
    input  in_valid, in_task, in_lat, out_ready,
    output in_ready, out_valid, out_task, out_slot, busy, stat_done_cnt
  );

endinterface
`default_nettype wire

// File: rtl/task_exec_slot.sv
`default_nettype none
// ============================================================================
// Module      : task_exec_slot
// Description : One execution slot: holds a task word and a latency
//               down-counter, walks IDLE -> RUN -> DONE -> IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module task_exec_slot
  import task_exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAT_W  = DEF_LAT_W
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              load,
  input  wire logic [DATA_W-1:0] load_task,
  input  wire logic [LAT_W-1:0]  load_lat,
  input  wire logic              retire,
  output slot_state_e            state,
  output logic      [DATA_W-1:0] task_word
);

  slot_state_e       r_state;
  slot_state_e       w_state_nxt;
  logic [LAT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_task;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: a loaded slot runs until its counter is exhausted, then waits for retire.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (load)           w_state_nxt = RUN;
      RUN:     if (r_cnt == '0)    w_state_nxt = DONE;
      DONE:    if (retire)         w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  // Task word capture and latency countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_task <= '0;
      r_cnt  <= '0;
    end else if (load && (r_state == IDLE)) begin
      r_task <= load_task;
      r_cnt  <= load_lat;
    end else if ((r_state == RUN) && (r_cnt != '0)) begin
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign state     = r_state;
  assign task_word = r_task;

endmodule
`default_nettype wire

// File: rtl/task_exec_pool.sv
`default_nettype none
// ============================================================================
// Module      : task_exec_pool
// Description : Multi-slot task executor. Accepts tasks into the lowest free
//               slot, runs them with per-task latency, and returns results
//               through a round-robin arbiter that locks its grant while the
//               consumer back-pressures.
//               Optional build macro: TASK_EXEC_STATS_EN enables the 16-bit
//               completion counter on stat_done_cnt (tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module task_exec_pool
  import task_exec_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int LAT_W     = DEF_LAT_W
) (
  input wire logic        clk,
  input wire logic        rst_n,
  task_exec_pool_if.slave bus
);

  localparam int SLOT_W = slot_w(NUM_SLOTS);

  slot_state_e          w_state [NUM_SLOTS];
  logic [DATA_W-1:0]    w_task  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_idle;
  logic [NUM_SLOTS-1:0] w_done;
  logic [NUM_SLOTS-1:0] w_load;
  logic [NUM_SLOTS-1:0] w_retire;

  logic [SLOT_W-1:0]    w_alloc;
  logic                 w_any_idle;
  logic                 w_accept;
  logic [SLOT_W-1:0]    w_gnt_rr;
  logic [SLOT_W-1:0]    w_gnt;
  logic                 w_out_valid;
  logic                 w_hs;

  logic [SLOT_W-1:0]    r_rr_ptr;
  logic                 r_lock;
  logic [SLOT_W-1:0]    r_lock_slot;

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      task_exec_slot #(
        .DATA_W (DATA_W),
        .LAT_W  (LAT_W)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load[i]),
        .load_task (bus.in_task),
        .load_lat  (bus.in_lat),
        .retire    (w_retire[i]),
        .state     (w_state[i]),
        .task_word (w_task[i])
      );
    end
  endgenerate

  // Decode slot states into free / finished masks.
  always_comb begin
    w_idle = '0;
    w_done = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_idle[i] = (w_state[i] == IDLE);
      w_done[i] = (w_state[i] == DONE);
    end
  end

  // Allocator: lowest-index free slot; uses current states only, so a slot
  // retired this cycle cannot be refilled until the next one.
  always_comb begin
    w_alloc    = '0;
    w_any_idle = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_idle[i]) begin
        w_alloc    = SLOT_W'(i);
        w_any_idle = 1'b1;
      end
    end
  end

  // Round-robin pick: first finished slot at or after the pointer.
  always_comb begin
    int idx;
    logic found;
    w_gnt_rr = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_SLOTS;
      if (!found && w_done[idx]) begin
        found    = 1'b1;
        w_gnt_rr = SLOT_W'(idx);
      end
    end
  end

  assign w_gnt       = r_lock ? r_lock_slot : w_gnt_rr;
  assign w_out_valid = |w_done;
  assign w_hs        = w_out_valid && bus.out_ready;
  assign w_accept    = bus.in_valid && w_any_idle;

  // One-hot load and retire strobes for the slots.
  always_comb begin
    w_load   = '0;
    w_retire = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_load[i]   = w_accept && (w_alloc == SLOT_W'(i));
      w_retire[i] = w_hs && (w_gnt == SLOT_W'(i));
    end
  end

  // Arbiter pointer and grant lock: a presented-but-stalled grant is frozen
  // so a slot finishing later cannot steal the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_lock      <= 1'b0;
      r_lock_slot <= '0;
    end else if (w_hs) begin
      r_rr_ptr    <= SLOT_W'((int'(w_gnt) + 1) % NUM_SLOTS);
      r_lock      <= 1'b0;
    end else if (w_out_valid) begin
      r_lock      <= 1'b1;
      r_lock_slot <= w_gnt;
    end
  end

  assign bus.in_ready  = w_any_idle;
  assign bus.out_valid = w_out_valid;
  assign bus.out_task  = w_out_valid ? w_task[w_gnt] : '0;
  assign bus.out_slot  = w_out_valid ? w_gnt : '0;
  assign bus.busy      = ~w_idle;

`ifdef TASK_EXEC_STATS_EN
  logic [STAT_W-1:0] r_stat_cnt;

  // Completion counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_stat_cnt <= '0;
    else if (w_hs) r_stat_cnt <= r_stat_cnt + 1'b1;
  end

  assign bus.stat_done_cnt = r_stat_cnt;
`else
  assign bus.stat_done_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_task_exec_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_task_exec_pool
// Description : Self-checking bench for task_exec_pool. A cycle-level model
//               tracks which slots hold a task, when each task becomes ready
//               (accept edge + latency + 1), the round-robin pointer and the
//               stalled grant, and compares every DUT output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_task_exec_pool;
  import task_exec_pkg::*;

  localparam int N = 4;

  logic clk;
  logic rst_n;

  task_exec_pool_if #(.DATA_W(8), .NUM_SLOTS(N), .LAT_W(3)) bus ();

  task_exec_pool #(.DATA_W(8), .NUM_SLOTS(N), .LAT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  bit          occ   [N];
  logic [7:0]  mtask [N];
  int          mlat  [N];
  int          macc  [N];
  int          edge_n;
  int          rr;
  bit          lock;
  int          lslot;
  logic [15:0] mstat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      occ[i] = 0; mtask[i] = '0; mlat[i] = 0; macc[i] = 0;
    end
    rr = 0; lock = 0; lslot = 0; mstat = '0;
  endtask

  function automatic logic [15:0] exp_stat();
`ifdef TASK_EXEC_STATS_EN
    return mstat;
`else
    return 16'h0;
`endif
  endfunction

  // Assert reset asynchronously between edges and check outputs immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready",  32'(bus.in_ready),      32'd1);
    check("rst_out_valid", 32'(bus.out_valid),     32'd0);
    check("rst_out_task",  32'(bus.out_task),      32'd0);
    check("rst_out_slot",  32'(bus.out_slot),      32'd0);
    check("rst_busy",      32'(bus.busy),          32'd0);
    check("rst_stat",      32'(bus.stat_done_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare all outputs, advance the model.
  task automatic step(input logic v, input logic [7:0] t, input logic [2:0] l,
                      input logic r, output logic acc);
    int         alloc;
    int         g;
    logic       exp_ready;
    logic       ov;
    bit         done [N];
    logic [3:0] busy_e;
    bus.in_valid  = v;
    bus.in_task   = t;
    bus.in_lat    = l;
    bus.out_ready = r;
    #1;
    exp_ready = 1'b0; alloc = -1; ov = 1'b0; g = 0; busy_e = '0;
    for (int i = 0; i < N; i++) begin
      busy_e[i] = occ[i];
      done[i]   = occ[i] && (edge_n >= macc[i] + mlat[i] + 2);
      if (done[i]) ov = 1'b1;
      if (!occ[i]) begin
        exp_ready = 1'b1;
        if (alloc < 0) alloc = i;
      end
    end
    if (lock) g = lslot;
    else begin
      for (int k = N - 1; k >= 0; k--)
        if (done[(rr + k) % N]) g = (rr + k) % N;
    end
    check("in_ready",  32'(bus.in_ready),      32'(exp_ready));
    check("out_valid", 32'(bus.out_valid),     32'(ov));
    check("out_task",  32'(bus.out_task),      ov ? 32'(mtask[g]) : 32'd0);
    check("out_slot",  32'(bus.out_slot),      ov ? 32'(g) : 32'd0);
    check("busy",      32'(bus.busy),          32'(busy_e));
    check("stat",      32'(bus.stat_done_cnt), 32'(exp_stat()));
    @(posedge clk);
    if (ov && r) begin
      occ[g] = 0; rr = (g + 1) % N; lock = 0; mstat = mstat + 16'd1;
    end else if (ov) begin
      lock = 1; lslot = g;
    end
    acc = 1'b0;
    if (v && exp_ready) begin
      occ[alloc] = 1; mtask[alloc] = t; mlat[alloc] = int'(l); macc[alloc] = edge_n;
      acc = 1'b1;
    end
    edge_n++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic r);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 3'd0, r, a);
  endtask

  initial begin
    logic       a;
    logic       pv;
    logic [7:0] pt;
    logic [2:0] pl;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_task = '0; bus.in_lat = '0; bus.out_ready = 1'b0;
    edge_n = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single task, latency 5.
    step(1'b1, 8'hA5, 3'd5, 1'b1, a);
    idle(9, 1'b1);

    // Fill the pool with back-pressure; fifth task held at the input.
    step(1'b1, 8'h01, 3'd7, 1'b0, a);
    step(1'b1, 8'h02, 3'd7, 1'b0, a);
    step(1'b1, 8'h03, 3'd7, 1'b0, a);
    step(1'b1, 8'h04, 3'd7, 1'b0, a);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h05, 3'd7, 1'b0, a);

    // Toggle out_ready: round-robin order with lock, freed slot refilled next cycle.
    for (int i = 0; i < 8; i++) step(1'b1, 8'h05 + 8'(i / 2), 3'd7, 1'(i % 2), a);
    idle(24, 1'b1);

    // Mixed latency: short task overtakes a long one.
    step(1'b1, 8'h11, 3'd7, 1'b1, a);
    step(1'b1, 8'h22, 3'd0, 1'b1, a);
    idle(12, 1'b1);

    // Three retirements from a clean counter, then reset with three tasks running.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + 8'(i), 3'd0, 1'b1, a);
    idle(6, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h40 + 8'(i), 3'd7, 1'b1, a);
    idle(2, 1'b1);
    do_reset();
    idle(2, 1'b1);

    // Randomized traffic; an unaccepted task is held unchanged.
    pv = 1'b0; pt = '0; pl = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pv && ($urandom_range(0, 99) < 60)) begin
        pv = 1'b1;
        pt = 8'($urandom);
        pl = 3'($urandom);
      end
      step(pv, pt, pl, 1'($urandom_range(0, 99) < 50), a);
      if (a) pv = 1'b0;
    end
    idle(20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/task_exec_pool.md
# task_exec_pool

Multi-slot task executor: accepts tasks over a valid/ready handshake, runs up to NUM_SLOTS of them concurrently, each with its own per-task latency, and returns completed tasks over a second valid/ready handshake tagged with the slot that ran them. It sits between the scheduler's dispatch port and the completion/retire logic. It is the parametrised successor to the single-slot fixed-delay executor, adding concurrency, variable latency and output back-pressure.

## Interface
- DATA_W, 8, task word width
- NUM_SLOTS, 4, concurrent execution slots (1..16)
- LAT_W, 3, width of per-task latency field
- SLOT_W, $clog2(NUM_SLOTS) (min 1), slot index width
- clk  in  1  the block's only clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  task offered
- in_ready  out  1  at least one slot IDLE
- in_task  in  DATA_W  task word
- in_lat  in  LAT_W  extra run cycles for this task
- out_valid  out  1  completed task presented
- out_ready  in  1  consumer accepts
- out_task  out  DATA_W  completed task word
- out_slot  out  SLOT_W  slot that ran it
- busy  out  NUM_SLOTS  per-slot "not IDLE"
- stat_done_cnt  out  16  completions (see Configuration)

## Operation
- Per-slot state: IDLE, RUN, DONE. Each slot holds task word and LAT_W-bit down-counter.
- Accept: in_valid && in_ready at an edge → lowest-index IDLE slot loads in_task, counter <= in_lat, state RUN.
- RUN: counter==0 → DONE; else counter decrements.
- DONE: slot holds result until its output handshake, then IDLE.
- Output arbitration: round-robin among DONE slots starting at rr_ptr; out_valid = any slot DONE.
- Grant lock: once out_valid is high without out_ready, the granted slot stays presented (out_task/out_slot stable) until handshake; newly DONE slots never preempt it.
- On handshake: rr_ptr <= granted+1 (mod NUM_SLOTS), granted slot → IDLE.
- in_ready computed from current-cycle slot states only; a slot freed by this cycle's output handshake is not reusable until next cycle (no bypass).
- in_valid while !in_ready: task not taken; source must hold it.

## Timing
- Reset (rst_n low, any time, mid-task included): all slots IDLE, counters 0, rr_ptr 0, lock cleared; outputs in_ready=1, out_valid=0, out_task=0, out_slot=0, busy=0, stat_done_cnt=0. In-flight tasks discarded.
- Latency: accept at edge k with in_lat=L → slot DONE after edge k+L+1; out_valid visible in that cycle if slot is granted. L=0 → 1 cycle; L=max → 2^LAT_W cycles.
- out_task/out_slot combinational from the granted slot's registers; zero when out_valid=0.
- busy bit set from the accept edge through the output-handshake edge.
- All slots full: in_ready=0 until an output handshake retires one (ready the following cycle).
- Simultaneous accept and retire in one cycle: both take effect.

## Configuration
- TASK_EXEC_STATS_EN defined: stat_done_cnt increments on every output handshake, wraps at 2^16, reset to 0.
- Not defined: stat_done_cnt tied to 0, counter logic absent; all other behaviour identical.

## Structure
- Package task_exec_pkg: slot state enum (IDLE, RUN, DONE), default widths, stats width constant.
- One sub-module task_exec_slot: state, task register, down-counter; inputs load/load_task/load_lat/retire, outputs state and task. Pool instantiates NUM_SLOTS copies plus allocator, round-robin arbiter with lock, and optional stats counter.

## Test plan
- Single task: in_task=8'hA5, in_lat=5, out_ready=1 → out_valid after 6 cycles, out_task=8'hA5, out_slot=0, busy returns to 0.
- Fill pool: 4 back-to-back tasks 8'h01..8'h04, in_lat=7, out_ready=0 → in_ready drops after 4th accept; 5th held; busy=4'hF.
- Round-robin: all four DONE, out_ready toggled → out_slot order 0,1,2,3; out_task stable across each out_ready=0 cycle.
- Mixed latency: slot0 in_lat=7, slot1 in_lat=0 → slot1 (task 8'h22) retires first, out-of-order.
- Retire/accept same cycle with pool full → freed slot reused next cycle, not same cycle.
- Reset mid-run: rst_n low with 3 tasks in RUN → all outputs reset values immediately; with TASK_EXEC_STATS_EN, stat_done_cnt counts 3 after three retirements then 0 after reset.
